// File: rtl/alu_regfile_if.sv
// Writeback bus between the ALU and the register file.
// The ALU side is the master; the register file is the slave.
interface alu_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    logic              i_wb_valid;
    logic              o_wb_ready;
    logic [ADDR_W-1:0] i_wa;
    logic [DATA_W-1:0] i_wd;
    logic              i_zf;

    modport master (
        output i_wb_valid,
        output i_wa,
        output i_wd,
        output i_zf,
        input  o_wb_ready
    );

    modport slave (
        input  i_wb_valid,
        input  i_wa,
        input  i_wd,
        input  i_zf,
        output o_wb_ready
    );
endinterface

// File: rtl/alu_regfile.sv
// ALU register file with a one-entry registered writeback stage.
// Optional macro REGFILE_BYPASS_EN forwards the pending stage to reads.
module alu_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_ra,
    input  logic [ADDR_W-1:0] i_rb,
    output logic [DATA_W-1:0] o_r,
    output logic [DATA_W-1:0] o_s,
    alu_regfile_if.slave      wb,
    output logic              o_zf_q,
    output logic              o_init,
    output logic              o_hazard
);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;

    logic              stg_vld;
    logic [ADDR_W-1:0] stg_addr;
    logic [DATA_W-1:0] stg_data;

    logic [DATA_W-1:0] mem [NREG];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    logic              accept;
    logic              hit_r;
    logic              hit_s;

    assign accept = wb.i_wb_valid && wb.o_wb_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        o_init        = 1'b0;
        wb.o_wb_ready = 1'b0;
        unique case (state)
            S_INIT: begin
                o_init  = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == ADDR_W'(NREG - 1)) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                wb.o_wb_ready = 1'b1;
            end
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stg_vld  <= 1'b0;
            stg_addr <= '0;
            stg_data <= '0;
            o_zf_q   <= 1'b0;
        end else begin
            stg_vld <= accept;
            if (accept) begin
                stg_addr <= wb.i_wa;
                stg_data <= wb.i_wd;
                o_zf_q   <= wb.i_zf;
            end
        end
    end

    // INIT clears one entry per cycle; RUN commits the stage unless it targets r0
    always_comb begin
        mem_we = 1'b0;
        mem_wa = stg_addr;
        mem_wd = stg_data;
        if (state == S_INIT) begin
            mem_we = 1'b1;
            mem_wa = cnt;
            mem_wd = '0;
        end else if (stg_vld && (stg_addr != '0)) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    assign hit_r    = stg_vld && (i_ra != '0) && (i_ra == stg_addr);
    assign hit_s    = stg_vld && (i_rb != '0) && (i_rb == stg_addr);
    assign o_hazard = hit_r || hit_s;

    always_comb begin
        o_r = '0;
        o_s = '0;
        if (state == S_RUN) begin
            if (i_ra != '0) o_r = mem[i_ra];
            if (i_rb != '0) o_s = mem[i_rb];
`ifdef REGFILE_BYPASS_EN
            if (hit_r) o_r = stg_data;
            if (hit_s) o_s = stg_data;
`endif
        end
    end

endmodule

// File: doc/alu_regfile.md
Name: alu_regfile

Overview:
- Register file on both sides of the single-cycle ALU: supplies the r/s operands and accepts the ALU result and zero flag as writeback.
- Writes pass through a one-entry writeback stage, so the ALU-to-regfile path is registered.
- After reset, a hardware sequencer clears the array to zero before any writeback is accepted.

Parameters:
DATA_W, 32, data width; matches ALU operand/result width
ADDR_W, 5, register address width
NREG, 32, number of registers; must equal 2**ADDR_W

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst_n  input  1  reset, asynchronous, active-low
i_ra  input  ADDR_W  read address for r operand
i_rb  input  ADDR_W  read address for s operand
o_r  output  DATA_W  r operand to ALU (combinational read)
o_s  output  DATA_W  s operand to ALU (combinational read)
i_wb_valid  input  1  writeback request
o_wb_ready  output  1  writeback can be accepted
i_wa  input  ADDR_W  writeback destination address
i_wd  input  DATA_W  writeback data (ALU result)
i_zf  input  1  ALU zero flag accompanying the writeback
o_zf_q  output  1  zero flag of the last accepted writeback
o_init  output  1  clear sequence in progress
o_hazard  output  1  i_ra or i_rb matches the pending stage address (nonzero)

Behaviour:
- Asynchronous reset (i_rst_n low), effective immediately:
  - state=INIT, clear counter=0, stage valid=0
  - o_zf_q=0, o_wb_ready=0, o_init=1
  - array contents are not reset directly; the INIT sequence clears them.
- State INIT:
  - Each cycle writes 0 to reg[cnt], then cnt increments.
  - After reg[NREG-1] is written, the next state is RUN. INIT lasts exactly NREG cycles (32 by default).
  - o_init=1 and o_wb_ready=0 throughout; i_wb_valid is ignored.
  - o_r and o_s are forced to 0.
- State RUN: o_init=0, o_wb_ready=1 permanently. RUN is never left except by reset.
- Handshake: a write is accepted on a rising edge where i_wb_valid && o_wb_ready.
  - At edge N, i_wa, i_wd and i_zf are captured into the stage and stage valid=1.
  - At edge N+1, the stage data is committed to reg[stage addr].
  - Back-to-back accepts are allowed: commit of the old entry and capture of the new one occur on the same edge, with no bubble.
  - If no new accept occurs, stage valid clears after commit.
- o_zf_q is updated with i_zf at every accepted write, including writes to address 0. It holds otherwise.
- Register 0 is hardwired to zero:
  - Reads of address 0 return 0.
  - A write to address 0 is accepted (handshake completes, o_zf_q updates) but is never committed.
  - Address 0 never raises o_hazard.
- Reads are combinational from the array. With the optional feature disabled, a read of the pending stage address returns the old array value and o_hazard=1 for that cycle.
- Both read ports may use the same address and return identical data.
- Boundary conditions:
  - Reset asserted mid-INIT restarts the clear at cnt=0.
  - Reset asserted mid-RUN discards an uncommitted stage entry; the array is then cleared by INIT anyway.
  - A read of an address being cleared in the same INIT cycle returns 0, because reads are forced to 0 during INIT.
  - Same-address consecutive writes commit in order: the last write wins.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: when stage valid=1 and a read address equals the (nonzero) stage address, that read port returns stage data instead of the array value. o_hazard still reports the match, for visibility only.
- Undefined: no forwarding; the stale array value is returned for one cycle as described in Behaviour.

Test Plan:
- INIT sequence: release reset, drive i_wb_valid=1 throughout -> o_init=1 and o_wb_ready=0 for exactly 32 cycles; no write lands; afterwards reading all 31 nonzero registers returns 0.
- Basic write/read: in RUN, write reg5=0x0000_00A5 with i_zf=0 -> o_zf_q=0 after edge N; i_ra=5 gives 0xA5 from edge N+1 onward; o_hazard=1 only in the cycle between edges N and N+1.
- Hazard/bypass: write reg7=0xDEAD_BEEF, read i_rb=7 in the next cycle -> without the macro o_s=old value (0) and o_hazard=1; with REGFILE_BYPASS_EN o_s=0xDEAD_BEEF.
- Back-to-back writes: reg3=0x1, reg3=0x2, reg4=0x3 on consecutive cycles -> o_wb_ready stays 1; final reg3=0x2, reg4=0x3.
- Register 0: write reg0=0xFFFF_FFFF with i_zf=1 -> handshake completes and o_zf_q=1; o_r for i_ra=0 stays 0; o_hazard stays 0.
- Mid-operation reset: accept write reg9=0x55, assert i_rst_n low before edge N+1 -> o_init=1 immediately; after the re-INIT completes, reg9 reads 0 and o_zf_q=0.
